// File: rtl/alarm_sequencer_pkg.sv
// Shared types and constants for the egg-timer alarm sequencer.
// Tone-select helpers keep the mode decoding in one place.
package alarm_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BEEP_ON  = 2'd1,
        BEEP_OFF = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [2:0] ROTATE_MODE = 3'd7;
    localparam int         NUM_TONES   = 5;
    localparam logic [2:0] TONE_MAX    = 3'd4;

    // Modes above TONE_MAX (5, 6 and rotate) all start on tone 0.
    function automatic logic [2:0] start_tone(input logic [2:0] mode);
        logic [2:0] tone;
        if (mode > TONE_MAX) begin
            tone = 3'd0;
        end else begin
            tone = mode;
        end
        return tone;
    endfunction

    function automatic logic [2:0] next_tone(input logic [2:0] tone);
        logic [2:0] nxt;
        if (tone >= TONE_MAX) begin
            nxt = 3'd0;
        end else begin
            nxt = tone + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/alarm_sequencer_tick_prescaler.sv
// Free-running tick divider; the count is held at zero while disabled so
// that every enabled run starts phase-aligned.
module tick_prescaler #(
    parameter int DIV = 5000
) (
    input  logic pulse_5MHz,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_r;

    // Divider count: 0..DIV-1 while enabled, cleared otherwise.
    always_ff @(posedge pulse_5MHz or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (!en) begin
            count_r <= '0;
        end else if (count_r == LAST) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

    assign tick = en && (count_r == LAST);

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm beep sequencer: gates the tone generator with an on/off cadence once
// the timer expires, optionally rotating tones, until acknowledged or done.
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int TICK_DIV       = 5000,
    parameter int ON_TICKS       = 300,
    parameter int OFF_TICKS      = 200,
    parameter int BEEPS_PER_TONE = 4,
    parameter int MAX_BEEPS      = 40
) (
    input  logic                             pulse_5MHz,
    input  logic                             reset,
    input  logic                             endtime,
    input  logic                             ack,
    input  logic [2:0]                       mode_sel,
    output logic                             endsound,
    output logic [2:0]                       audioselection,
    output logic                             alarm_active,
    output logic [$clog2(MAX_BEEPS+1)-1:0]   beep_count
);

    localparam int BC_W   = $clog2(MAX_BEEPS + 1);
    localparam int PH_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TB_W   = $clog2(BEEPS_PER_TONE + 1);

    localparam logic [PH_W-1:0] ON_LAST   = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] OFF_LAST  = PH_W'(OFF_TICKS - 1);
    localparam logic [TB_W-1:0] TONE_LAST = TB_W'(BEEPS_PER_TONE - 1);
    localparam logic [BC_W-1:0] BEEP_MAX  = BC_W'(MAX_BEEPS);

    state_t          state_r;
    logic            endtime_d_r;
    logic            rotate_r;
    logic [PH_W-1:0] phase_cnt_r;
    logic [TB_W-1:0] tone_beeps_r;
    logic            endsound_r;
    logic [2:0]      audiosel_r;
    logic            alarm_active_r;
    logic [BC_W-1:0] beep_count_r;

    logic            tick_s;
    logic            start_s;
    logic            prescale_en_s;
    logic [BC_W-1:0] beep_next_s;

    assign start_s       = endtime && !endtime_d_r;
    assign prescale_en_s = (state_r == BEEP_ON) || (state_r == BEEP_OFF);

    // Saturating completed-beep count used at the end of each off phase.
    always_comb begin
        beep_next_s = beep_count_r;
        if (beep_count_r != BEEP_MAX) begin
            beep_next_s = beep_count_r + BC_W'(1);
        end else begin
            beep_next_s = beep_count_r;
        end
    end

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_tick_prescaler (
        .pulse_5MHz (pulse_5MHz),
        .reset      (reset),
        .en         (prescale_en_s),
        .tick       (tick_s)
    );

    // Sequencer FSM with phase counter, tone rotation and registered outputs.
    always_ff @(posedge pulse_5MHz or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            endtime_d_r    <= 1'b0;
            rotate_r       <= 1'b0;
            phase_cnt_r    <= '0;
            tone_beeps_r   <= '0;
            endsound_r     <= 1'b1;
            audiosel_r     <= 3'd0;
            alarm_active_r <= 1'b0;
            beep_count_r   <= '0;
        end else begin
            endtime_d_r <= endtime;
            if (!endtime) begin
                state_r        <= IDLE;
                endsound_r     <= 1'b1;
                alarm_active_r <= 1'b0;
                phase_cnt_r    <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_s) begin
                            state_r        <= BEEP_ON;
                            endsound_r     <= 1'b0;
                            alarm_active_r <= 1'b1;
                            phase_cnt_r    <= '0;
                            tone_beeps_r   <= '0;
                            beep_count_r   <= '0;
                            rotate_r       <= (mode_sel == ROTATE_MODE);
                            audiosel_r     <= start_tone(mode_sel);
                        end else begin
                            endsound_r     <= 1'b1;
                            alarm_active_r <= 1'b0;
                        end
                    end
                    BEEP_ON: begin
                        if (ack) begin
                            state_r        <= DONE;
                            endsound_r     <= 1'b1;
                            alarm_active_r <= 1'b0;
                        end else if (tick_s) begin
                            if (phase_cnt_r == ON_LAST) begin
                                state_r     <= BEEP_OFF;
                                endsound_r  <= 1'b1;
                                phase_cnt_r <= '0;
                            end else begin
                                phase_cnt_r <= phase_cnt_r + PH_W'(1);
                            end
                        end
                    end
                    BEEP_OFF: begin
                        if (ack) begin
                            state_r        <= DONE;
                            endsound_r     <= 1'b1;
                            alarm_active_r <= 1'b0;
                        end else if (tick_s) begin
                            if (phase_cnt_r == OFF_LAST) begin
                                phase_cnt_r  <= '0;
                                beep_count_r <= beep_next_s;
                                if (beep_next_s == BEEP_MAX) begin
                                    state_r        <= DONE;
                                    endsound_r     <= 1'b1;
                                    alarm_active_r <= 1'b0;
                                end else begin
                                    state_r    <= BEEP_ON;
                                    endsound_r <= 1'b0;
                                    // Tone advances only as the next beep starts.
                                    if (rotate_r) begin
                                        if (tone_beeps_r == TONE_LAST) begin
                                            tone_beeps_r <= '0;
                                            audiosel_r   <= next_tone(audiosel_r);
                                        end else begin
                                            tone_beeps_r <= tone_beeps_r + TB_W'(1);
                                        end
                                    end
                                end
                            end else begin
                                phase_cnt_r <= phase_cnt_r + PH_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        endsound_r     <= 1'b1;
                        alarm_active_r <= 1'b0;
                    end
                    default: begin
                        state_r        <= IDLE;
                        endsound_r     <= 1'b1;
                        alarm_active_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign endsound       = endsound_r;
    assign audioselection = audiosel_r;
    assign alarm_active   = alarm_active_r;
    assign beep_count     = beep_count_r;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: a mode/tone vector table, timed
// cadence sequences, and a scoreboard of expected tones per beep start.
module tb_alarm_sequencer;

    localparam int TD  = 4;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int BPT = 2;
    localparam int MX  = 5;
    localparam int MX2 = 12;
    localparam int BEEP_CYC = (ON + OFF) * TD;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic endtime = 1'b0;
    logic ack = 1'b0;
    logic [2:0] mode_sel = 3'd0;
    logic endsound;
    logic [2:0] audiosel;
    logic alarm_active;
    logic [$clog2(MX+1)-1:0] beep_count;

    logic endtime2 = 1'b0;
    logic ack2 = 1'b0;
    logic [2:0] mode_sel2 = 3'd7;
    logic endsound2;
    logic [2:0] audiosel2;
    logic alarm_active2;
    logic [$clog2(MX2+1)-1:0] beep_count2;

    int tests = 0;
    int fails = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_q2[$];

    typedef struct {
        logic [2:0] mode;
        logic [2:0] tone;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    alarm_sequencer #(
        .TICK_DIV(TD), .ON_TICKS(ON), .OFF_TICKS(OFF),
        .BEEPS_PER_TONE(BPT), .MAX_BEEPS(MX)
    ) dut (
        .pulse_5MHz(clk), .reset(reset), .endtime(endtime), .ack(ack),
        .mode_sel(mode_sel), .endsound(endsound), .audioselection(audiosel),
        .alarm_active(alarm_active), .beep_count(beep_count)
    );

    alarm_sequencer #(
        .TICK_DIV(TD), .ON_TICKS(ON), .OFF_TICKS(OFF),
        .BEEPS_PER_TONE(BPT), .MAX_BEEPS(MX2)
    ) dut12 (
        .pulse_5MHz(clk), .reset(reset), .endtime(endtime2), .ack(ack2),
        .mode_sel(mode_sel2), .endsound(endsound2), .audioselection(audiosel2),
        .alarm_active(alarm_active2), .beep_count(beep_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: each falling endsound edge pops the tone expected for that beep.
    initial begin : monitor
        logic prev1;
        logic prev2;
        prev1 = 1'b1;
        prev2 = 1'b1;
        forever begin
            @(negedge clk);
            if (prev1 && endsound === 1'b0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beep_unexpected: got tone %0d, expected no beep", audiosel);
                end else begin
                    check("beep_tone", audiosel, exp_q.pop_front());
                end
            end
            if (prev2 && endsound2 === 1'b0) begin
                if (exp_q2.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beep12_unexpected: got tone %0d, expected no beep", audiosel2);
                end else begin
                    check("beep12_tone", audiosel2, exp_q2.pop_front());
                end
            end
            prev1 = endsound;
            prev2 = endsound2;
        end
    end

    initial begin : stim
        logic ok_on;
        logic ok_off;
        logic quiet;
        vecs[0] = '{3'd0, 3'd0};
        vecs[1] = '{3'd2, 3'd2};
        vecs[2] = '{3'd3, 3'd3};
        vecs[3] = '{3'd4, 3'd4};
        vecs[4] = '{3'd5, 3'd0};
        vecs[5] = '{3'd6, 3'd0};
        vecs[6] = '{3'd7, 3'd0};

        cycles(2);
        check("rst_endsound", endsound, 1);
        check("rst_audiosel", audiosel, 0);
        check("rst_active", alarm_active, 0);
        check("rst_count", beep_count, 0);
        reset = 1'b0;
        cycles(2);

        // Fixed tone 1: exact 12/8 cadence for five beeps, then DONE.
        mode_sel = 3'd1;
        repeat (MX) exp_q.push_back(3'd1);
        endtime = 1'b1;
        for (int b = 0; b < MX; b++) begin
            ok_on = 1'b1;
            for (int i = 0; i < ON * TD; i++) begin
                @(negedge clk);
                if (endsound !== 1'b0 || alarm_active !== 1'b1 || audiosel !== 3'd1) ok_on = 1'b0;
            end
            check("t1_on_phase", ok_on, 1);
            ok_off = 1'b1;
            for (int i = 0; i < OFF * TD; i++) begin
                @(negedge clk);
                if (endsound !== 1'b1 || alarm_active !== 1'b1) ok_off = 1'b0;
            end
            check("t1_off_phase", ok_off, 1);
            check("t1_count_in_off", beep_count, b);
        end
        @(negedge clk);
        check("t1_done_endsound", endsound, 1);
        check("t1_done_active", alarm_active, 0);
        check("t1_done_count", beep_count, MX);
        check("t1_done_audiosel", audiosel, 1);
        cycles(10);
        check("t1_done_hold", alarm_active, 0);
        endtime = 1'b0;
        @(negedge clk);
        check("t1_idle_count_hold", beep_count, MX);

        // Mode decoding table, each alarm dismissed by ack in the first beep.
        for (int v = 0; v < 7; v++) begin
            mode_sel = vecs[v].mode;
            exp_q.push_back(vecs[v].tone);
            endtime = 1'b1;
            @(negedge clk);
            check("tbl_tone", audiosel, vecs[v].tone);
            check("tbl_on", endsound, 0);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            check("tbl_ack_silence", endsound, 1);
            check("tbl_ack_done", alarm_active, 0);
            endtime = 1'b0;
            @(negedge clk);
        end

        // Rotate mode to automatic silence.
        mode_sel = 3'd7;
        exp_q.push_back(3'd0); exp_q.push_back(3'd0);
        exp_q.push_back(3'd1); exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        endtime = 1'b1;
        cycles(MX * BEEP_CYC + 1);
        check("t2_done_active", alarm_active, 0);
        check("t2_done_count", beep_count, MX);
        check("t2_last_tone", audiosel, 2);
        endtime = 1'b0;
        @(negedge clk);

        // Rotate wrap on the 12-beep instance.
        for (int k = 0; k < MX2; k++) exp_q2.push_back(3'((k / BPT) % 5));
        endtime2 = 1'b1;
        cycles(MX2 * BEEP_CYC + 1);
        check("t2w_done_active", alarm_active2, 0);
        check("t2w_done_count", beep_count2, MX2);
        check("t2w_last_tone", audiosel2, 0);
        endtime2 = 1'b0;
        @(negedge clk);

        // Ack mid second beep, no restart while endtime stays high.
        mode_sel = 3'd1;
        exp_q.push_back(3'd1); exp_q.push_back(3'd1);
        endtime = 1'b1;
        cycles(BEEP_CYC + 4);
        check("t3_pre_ack", endsound, 0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("t3_ack_silence", endsound, 1);
        check("t3_ack_done", alarm_active, 0);
        check("t3_ack_count", beep_count, 1);
        quiet = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (endsound !== 1'b1 || alarm_active !== 1'b0) quiet = 1'b0;
        end
        check("t3_no_restart", quiet, 1);
        endtime = 1'b0;
        @(negedge clk);
        exp_q.push_back(3'd1);
        endtime = 1'b1;
        @(negedge clk);
        check("t3_new_count", beep_count, 0);
        check("t3_new_on", endsound, 0);
        check("t3_new_active", alarm_active, 1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        endtime = 1'b0;
        @(negedge clk);

        // Endtime drops mid off phase together with ack.
        mode_sel = 3'd2;
        exp_q.push_back(3'd2);
        endtime = 1'b1;
        cycles(ON * TD + 3);
        check("t4_in_off", alarm_active, 1);
        endtime = 1'b0;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("t4_idle_endsound", endsound, 1);
        check("t4_idle_active", alarm_active, 0);
        check("t4_idle_count", beep_count, 0);
        @(negedge clk);
        check("t4_stay_idle", alarm_active, 0);

        // Asynchronous reset mid second beep, release with endtime high.
        mode_sel = 3'd3;
        exp_q.push_back(3'd3); exp_q.push_back(3'd3);
        endtime = 1'b1;
        cycles(BEEP_CYC + 5);
        check("t5_pre_count", beep_count, 1);
        check("t5_pre_tone", audiosel, 3);
        #2 reset = 1'b1;
        #1;
        check("t5_async_endsound", endsound, 1);
        check("t5_async_audiosel", audiosel, 0);
        check("t5_async_count", beep_count, 0);
        check("t5_async_active", alarm_active, 0);
        @(negedge clk);
        exp_q.push_back(3'd3);
        reset = 1'b0;
        @(negedge clk);
        check("t5_restart_on", endsound, 0);
        check("t5_restart_active", alarm_active, 1);
        check("t5_restart_tone", audiosel, 3);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        endtime = 1'b0;
        @(negedge clk);

        // mode_sel change after the latch is ignored.
        mode_sel = 3'd3;
        exp_q.push_back(3'd3); exp_q.push_back(3'd3);
        endtime = 1'b1;
        @(negedge clk);
        mode_sel = 3'd2;
        cycles(BEEP_CYC + 2);
        check("t6_tone_kept", audiosel, 3);
        check("t6_second_beep_on", endsound, 0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        endtime = 1'b0;
        cycles(3);

        check("sb_queue_empty", exp_q.size(), 0);
        check("sb12_queue_empty", exp_q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
